// File: rtl/ariane_ace.sv
// ACE snoop channel bundles (AC request, CR response, CD data) exchanged
// between a snoop initiator and the snooped cache.
package ariane_ace;

  localparam int unsigned AddrWidth   = 64;
  localparam int unsigned CdDataWidth = 64;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    snoop_pkg::acsnoop_t  snoop;
    logic [2:0]           prot;
  } ac_chan_t;

  typedef struct packed {
    logic [CdDataWidth-1:0] data;
    logic                   last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic               ac_ready;
    logic               cr_valid;
    snoop_pkg::crresp_t cr_resp;
    logic               cd_valid;
    cd_chan_t           cd;
  } snoop_resp_t;

endpackage

// File: rtl/snoop_pkg.sv
// Shared snoop types: ACE snoop opcodes, CR response bits and the result
// record the initiator hands back once a snoop has completed.
package snoop_pkg;

  localparam int unsigned CacheLineWidth = 128;

  typedef enum logic [3:0] {
    READ_ONCE             = 4'b0000,
    READ_SHARED           = 4'b0001,
    READ_CLEAN            = 4'b0010,
    READ_NOT_SHARED_DIRTY = 4'b0011,
    READ_UNIQUE           = 4'b0111,
    CLEAN_SHARED          = 4'b1000,
    CLEAN_INVALID         = 4'b1001,
    MAKE_INVALID          = 4'b1101
  } acsnoop_t;

  // Bit order follows the ACE CRRESP field, MSB first.
  typedef struct packed {
    logic wasUnique;
    logic isShared;
    logic passDirty;
    logic error;
    logic dataTransfer;
  } crresp_t;

  typedef struct packed {
    crresp_t                   crresp;
    logic [CacheLineWidth-1:0] data;
    logic                      data_valid;
    logic                      proto_err;
  } snoop_result_t;

endpackage

// File: rtl/snoop_initiator.sv
// Issues one ACE snoop at a time: sends AC, collects CR and, when data is
// transferred, the full cache line over CD, then presents a single result.
module snoop_initiator
  import snoop_pkg::*;
#(
  parameter int unsigned LineWidth = 128,
  parameter int unsigned BeatWidth = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    busy_o,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [63:0]             req_addr_i,
  input  acsnoop_t                req_snoop_i,
  output ariane_ace::snoop_req_t  snoop_req_o,
  input  ariane_ace::snoop_resp_t snoop_resp_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output snoop_result_t           rsp_o
);

  localparam int unsigned NumBeats     = LineWidth / BeatWidth;
  localparam int unsigned BeatCntWidth = $clog2(NumBeats);
  localparam logic [BeatCntWidth-1:0] LastBeat = BeatCntWidth'(NumBeats - 1);

  if ((LineWidth % BeatWidth) != 0 || NumBeats < 2) begin : gen_bad_beat_geometry
    $error("snoop_initiator: LineWidth must be an integer multiple (>= 2) of BeatWidth");
  end
  if (LineWidth != CacheLineWidth || BeatWidth != ariane_ace::CdDataWidth) begin : gen_bad_type_width
    $error("snoop_initiator: LineWidth/BeatWidth must match the snoop_pkg/ariane_ace type widths");
  end

  typedef enum logic [2:0] {
    IDLE,
    SEND_AC,
    WAIT_CR,
    RECV_CD,
    SEND_RSP
  } state_e;

  state_e                  state_q, state_d;
  logic [63:0]             addr_q;
  acsnoop_t                snoop_q;
  crresp_t                 crresp_q;
  logic [LineWidth-1:0]    data_q;
  logic                    data_valid_q;
  logic                    proto_err_q;
  logic [BeatCntWidth-1:0] beat_q;
  logic                    cmd_accept;
  logic                    last_beat;

  assign cmd_accept = req_valid_i & req_ready_o;
  assign last_beat  = (beat_q == LastBeat);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req_valid_i)              state_d = SEND_AC;
      SEND_AC:  if (snoop_resp_i.ac_ready)    state_d = WAIT_CR;
      WAIT_CR:  if (snoop_resp_i.cr_valid)
                  state_d = snoop_resp_i.cr_resp.dataTransfer ? RECV_CD : SEND_RSP;
      RECV_CD:  if (snoop_resp_i.cd_valid && last_beat) state_d = SEND_RSP;
      SEND_RSP: if (rsp_ready_i)              state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // Every handshake output is gated by rst_ni so nothing is offered while reset is held.
  always_comb begin
    req_ready_o           = 1'b0;
    rsp_valid_o           = 1'b0;
    busy_o                = rst_ni & (state_q != IDLE);
    snoop_req_o           = '0;
    snoop_req_o.ac.addr   = addr_q;
    snoop_req_o.ac.snoop  = snoop_q;
    if (rst_ni) begin
      case (state_q)
        IDLE:     req_ready_o          = 1'b1;
        SEND_AC:  snoop_req_o.ac_valid = 1'b1;
        WAIT_CR:  snoop_req_o.cr_ready = 1'b1;
        RECV_CD:  snoop_req_o.cd_ready = 1'b1;
        SEND_RSP: rsp_valid_o          = 1'b1;
        default:  ;
      endcase
    end
    rsp_o            = '0;
    rsp_o.crresp     = crresp_q;
    rsp_o.data       = data_q;
    rsp_o.data_valid = data_valid_q;
    rsp_o.proto_err  = proto_err_q;
  end

  // A wrong CD last flag only marks the result; the line is still collected in full.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q       <= '0;
      snoop_q      <= READ_ONCE;
      crresp_q     <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      proto_err_q  <= 1'b0;
      beat_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_accept) begin
            addr_q       <= req_addr_i;
            snoop_q      <= req_snoop_i;
            crresp_q     <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            proto_err_q  <= 1'b0;
            beat_q       <= '0;
          end
        end
        WAIT_CR: begin
          if (snoop_resp_i.cr_valid) crresp_q <= snoop_resp_i.cr_resp;
        end
        RECV_CD: begin
          if (snoop_resp_i.cd_valid) begin
            for (int k = 0; k < NumBeats; k++) begin
              if (beat_q == BeatCntWidth'(k)) data_q[k*BeatWidth +: BeatWidth] <= snoop_resp_i.cd.data;
            end
            if (snoop_resp_i.cd.last != last_beat) proto_err_q <= 1'b1;
            if (last_beat) data_valid_q <= 1'b1;
            beat_q <= beat_q + BeatCntWidth'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_initiator.sv
// Directed bench for snoop_initiator: a table of complete snoop transactions
// plus hand-written sequences for response backpressure and mid-burst reset.
module tb_snoop_initiator;
  import snoop_pkg::*;

  localparam int unsigned LineWidth = 128;
  localparam int StepLimit = 40;

  typedef struct {
    logic [63:0]          addr;
    acsnoop_t             snoop;
    int                   ac_delay;
    crresp_t              cr;
    logic [63:0]          beat0;
    logic                 last0;
    logic [63:0]          beat1;
    logic                 last1;
    bit                   noise;
    logic [LineWidth-1:0] exp_data;
    logic                 exp_dv;
    logic                 exp_perr;
    int                   exp_lat;
  } vec_t;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    busy_o;
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [63:0]             req_addr_i;
  acsnoop_t                req_snoop_i;
  ariane_ace::snoop_req_t  snoop_req_o;
  ariane_ace::snoop_resp_t snoop_resp_i;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  snoop_result_t           rsp_o;

  always #5 clk_i = ~clk_i;

  snoop_initiator #(
    .LineWidth(128),
    .BeatWidth(64)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .busy_o      (busy_o),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_snoop_i (req_snoop_i),
    .snoop_req_o (snoop_req_o),
    .snoop_resp_i(snoop_resp_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_o       (rsp_o)
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  int            lat;
  int            beats;
  bit            saw_cd;
  bit            saw_ac;
  vec_t          vecs[5];
  vec_t          h_first;
  vec_t          h_second;
  snoop_result_t exp_rsp;

  function automatic crresp_t mk_cr(input logic wu, input logic sh, input logic pd,
                                    input logic er, input logic dt);
    crresp_t c;
    c.wasUnique    = wu;
    c.isShared     = sh;
    c.passDirty    = pd;
    c.error        = er;
    c.dataTransfer = dt;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic issue_cmd(input logic [63:0] addr, input acsnoop_t snoop);
    int waited = 0;
    while (!req_ready_o && waited < StepLimit) begin
      tick();
      waited++;
    end
    check("issue.req_ready", 160'(req_ready_o), 160'(1'b1));
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_snoop_i = snoop;
    tick();
    req_valid_i = 1'b0;
    lat = 1;
  endtask

  // Plays the snooped cache; optional noise drives CR/CD valid in states that must ignore them.
  task automatic run_responder(input vec_t v, input int stop_beats);
    int ac_wait = 0;
    beats  = 0;
    saw_cd = 1'b0;
    saw_ac = 1'b0;
    while (!rsp_valid_o && lat < StepLimit && !(stop_beats > 0 && beats >= stop_beats)) begin
      snoop_resp_i = '0;
      if (snoop_req_o.ac_valid) begin
        if (!saw_ac) begin
          check("ac.addr", 160'(snoop_req_o.ac.addr), 160'(v.addr));
          check("ac.snoop", 160'(snoop_req_o.ac.snoop), 160'(v.snoop));
          check("ac.prot", 160'(snoop_req_o.ac.prot), 160'(3'b000));
          saw_ac = 1'b1;
        end
        if (ac_wait >= v.ac_delay) snoop_resp_i.ac_ready = 1'b1;
        ac_wait++;
      end
      if (snoop_req_o.cr_ready) begin
        snoop_resp_i.cr_valid = 1'b1;
        snoop_resp_i.cr_resp  = v.cr;
      end else if (v.noise) begin
        snoop_resp_i.cr_valid = 1'b1;
        snoop_resp_i.cr_resp  = mk_cr(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      end
      if (snoop_req_o.cd_ready) begin
        saw_cd = 1'b1;
        snoop_resp_i.cd_valid = 1'b1;
        snoop_resp_i.cd.data  = (beats == 0) ? v.beat0 : v.beat1;
        snoop_resp_i.cd.last  = (beats == 0) ? v.last0 : v.last1;
        beats++;
      end else if (v.noise) begin
        snoop_resp_i.cd_valid = 1'b1;
        snoop_resp_i.cd.data  = 64'hDEAD_BEEF_DEAD_BEEF;
        snoop_resp_i.cd.last  = 1'b1;
      end
      tick();
      lat++;
    end
    snoop_resp_i = '0;
    if (lat >= StepLimit) begin
      n_checks++;
      $display("[TB] FAIL responder.timeout: got no rsp_valid_o after %0d cycles, expected within %0d", lat, v.exp_lat);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    issue_cmd(v.addr, v.snoop);
    run_responder(v, 0);
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    check({tag, ".rsp_valid"}, 160'(rsp_valid_o), 160'(1'b1));
    check({tag, ".latency"}, 160'(lat), 160'(v.exp_lat));
    check({tag, ".crresp"}, 160'(rsp_o.crresp), 160'(v.cr));
    check({tag, ".data"}, 160'(rsp_o.data), 160'(v.exp_data));
    check({tag, ".data_valid"}, 160'(rsp_o.data_valid), 160'(v.exp_dv));
    check({tag, ".proto_err"}, 160'(rsp_o.proto_err), 160'(v.exp_perr));
    check({tag, ".cd_ready_seen"}, 160'(saw_cd), 160'(v.cr.dataTransfer));
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check({tag, ".back_to_idle"}, 160'({busy_o, rsp_valid_o, req_ready_o}), 160'(3'b001));
  endtask

  initial begin
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_snoop_i  = READ_ONCE;
    rsp_ready_i  = 1'b0;
    snoop_resp_i = '0;

    vecs[0] = '{addr: 64'h0000_0000_8000_0040, snoop: READ_SHARED, ac_delay: 2,
                cr: mk_cr(1'b0, 1'b1, 1'b0, 1'b0, 1'b1),
                beat0: 64'h1111_1111_1111_1111, last0: 1'b0,
                beat1: 64'h2222_2222_2222_2222, last1: 1'b1, noise: 1'b0,
                exp_data: 128'h2222_2222_2222_2222_1111_1111_1111_1111,
                exp_dv: 1'b1, exp_perr: 1'b0, exp_lat: 7};
    vecs[1] = '{addr: 64'h0000_0000_0000_1000, snoop: CLEAN_INVALID, ac_delay: 0,
                cr: mk_cr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                beat0: 64'h5555_5555_5555_5555, last0: 1'b0,
                beat1: 64'h6666_6666_6666_6666, last1: 1'b1, noise: 1'b1,
                exp_data: '0, exp_dv: 1'b0, exp_perr: 1'b0, exp_lat: 3};
    vecs[2] = '{addr: 64'h0000_0000_4000_0080, snoop: READ_UNIQUE, ac_delay: 0,
                cr: mk_cr(1'b1, 1'b0, 1'b1, 1'b0, 1'b1),
                beat0: 64'hAAAA_AAAA_AAAA_AAAA, last0: 1'b1,
                beat1: 64'hBBBB_BBBB_BBBB_BBBB, last1: 1'b1, noise: 1'b0,
                exp_data: 128'hBBBB_BBBB_BBBB_BBBB_AAAA_AAAA_AAAA_AAAA,
                exp_dv: 1'b1, exp_perr: 1'b1, exp_lat: 5};
    vecs[3] = '{addr: 64'h0000_0000_0000_00C0, snoop: READ_ONCE, ac_delay: 1,
                cr: mk_cr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
                beat0: 64'h0, last0: 1'b0, beat1: 64'h0, last1: 1'b0, noise: 1'b0,
                exp_data: '0, exp_dv: 1'b0, exp_perr: 1'b0, exp_lat: 4};
    vecs[4] = '{addr: 64'hFFFF_FFFF_FFFF_FFC0, snoop: READ_CLEAN, ac_delay: 0,
                cr: mk_cr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1),
                beat0: 64'h0123_4567_89AB_CDEF, last0: 1'b0,
                beat1: 64'hFEDC_BA98_7654_3210, last1: 1'b0, noise: 1'b1,
                exp_data: 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF,
                exp_dv: 1'b1, exp_perr: 1'b1, exp_lat: 5};

    $display("[TB] reset");
    tick();
    tick();
    check("reset.handshakes_low", 160'({busy_o, req_ready_o, rsp_valid_o, snoop_req_o.ac_valid,
                                        snoop_req_o.cr_ready, snoop_req_o.cd_ready}), 160'(6'b0));
    check("reset.rsp_zero", 160'(rsp_o), 160'(0));
    rst_ni = 1'b1;
    #1;
    check("reset.idle_ready", 160'({busy_o, req_ready_o}), 160'(2'b01));

    $display("[TB] table vectors");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("v%0d", i));
    end

    $display("[TB] response backpressure with a pending command");
    h_first = '{addr: 64'h0000_0000_0000_2000, snoop: CLEAN_SHARED, ac_delay: 0,
                cr: mk_cr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
                beat0: 64'h0, last0: 1'b0, beat1: 64'h0, last1: 1'b0, noise: 1'b0,
                exp_data: '0, exp_dv: 1'b0, exp_perr: 1'b0, exp_lat: 3};
    h_second = '{addr: 64'h0000_0000_0000_3000, snoop: MAKE_INVALID, ac_delay: 0,
                 cr: mk_cr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
                 beat0: 64'h0, last0: 1'b0, beat1: 64'h0, last1: 1'b0, noise: 1'b0,
                 exp_data: '0, exp_dv: 1'b0, exp_perr: 1'b0, exp_lat: 3};
    applyStimulus(h_first);
    check("hold.latency", 160'(lat), 160'(h_first.exp_lat));
    exp_rsp        = '0;
    exp_rsp.crresp = h_first.cr;
    req_valid_i = 1'b1;
    req_addr_i  = h_second.addr;
    req_snoop_i = h_second.snoop;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("hold%0d.rsp_valid", i), 160'(rsp_valid_o), 160'(1'b1));
      check($sformatf("hold%0d.req_ready", i), 160'(req_ready_o), 160'(1'b0));
      check($sformatf("hold%0d.rsp", i), 160'(rsp_o), 160'(exp_rsp));
      if (i < 5) tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("hold.idle_after_handshake", 160'({busy_o, req_ready_o}), 160'(2'b01));
    tick();
    req_valid_i = 1'b0;
    check("hold.next_accepted", 160'({busy_o, snoop_req_o.ac_valid}), 160'(2'b11));
    lat = 1;
    run_responder(h_second, 0);
    checkOutput(h_second, "h1b");

    $display("[TB] reset in the middle of a data burst");
    issue_cmd(vecs[0].addr, vecs[0].snoop);
    run_responder(vecs[0], 1);
    check("midrst.in_recv_cd", 160'({busy_o, snoop_req_o.cd_ready}), 160'(2'b11));
    rst_ni = 1'b0;
    #1;
    check("midrst.outputs_low", 160'({busy_o, req_ready_o, rsp_valid_o, snoop_req_o.ac_valid,
                                      snoop_req_o.cr_ready, snoop_req_o.cd_ready}), 160'(6'b0));
    tick();
    rst_ni = 1'b1;
    #1;
    check("midrst.idle", 160'({busy_o, req_ready_o}), 160'(2'b01));
    check("midrst.rsp_zero", 160'(rsp_o), 160'(0));
    applyStimulus(vecs[4]);
    checkOutput(vecs[4], "midrst.after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/snoop_initiator.md
SNOOP_INITIATOR -- requirements
Module: snoop_initiator

Interface
REQ-001 SHALL have parameter LineWidth, default 128: cache-line width in bits.
REQ-002 SHALL have parameter BeatWidth, default 64: CD beat width in bits; NumBeats = LineWidth/BeatWidth; elaboration error if not an integer >= 2.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port busy_o, output, 1: high whenever state is not IDLE.
REQ-006 SHALL have port req_valid_i, input, 1: a snoop command is offered.
REQ-007 SHALL have port req_ready_o, output, 1: command accepted this cycle.
REQ-008 SHALL have port req_addr_i, input, 64: snoop address.
REQ-009 SHALL have port req_snoop_i, input, snoop_pkg::acsnoop_t: snoop type.
REQ-010 SHALL have port snoop_req_o, output, ariane_ace::snoop_req_t: ac_valid, ac, cr_ready, cd_ready toward the snooped cache.
REQ-011 SHALL have port snoop_resp_i, input, ariane_ace::snoop_resp_t: ac_ready, cr_valid, cr_resp, cd_valid, cd from the snooped cache.
REQ-012 SHALL have port rsp_valid_o, input-side handshake output, 1: result available.
REQ-013 SHALL have port rsp_ready_i, input, 1: result consumed.
REQ-014 SHALL have port rsp_o, output, snoop_pkg::snoop_result_t: crresp, data[LineWidth-1:0], data_valid, proto_err.

Function
REQ-015 SHALL implement FSM states IDLE, SEND_AC, WAIT_CR, RECV_CD, SEND_RSP.
REQ-016 IDLE SHALL drive req_ready_o=1 (while rst_ni=1); on req_valid_i&req_ready_o SHALL latch addr and snoop, clear data, data_valid, proto_err and beat counter, and go to SEND_AC next cycle.
REQ-017 SEND_AC SHALL drive ac_valid=1, ac.addr and ac.snoop from latched values, ac.prot='0, stable until ac_ready; on ac_ready SHALL go to WAIT_CR.
REQ-018 WAIT_CR SHALL drive cr_ready=1; on cr_valid SHALL latch cr_resp; if cr_resp.dataTransfer go to RECV_CD, else go to SEND_RSP.
REQ-019 RECV_CD SHALL drive cd_ready=1; each cd_valid beat k SHALL be stored at data[k*BeatWidth +: BeatWidth] and increment the beat counter.
REQ-020 cd.last SHALL be 0 on beats 0..NumBeats-2 and 1 on beat NumBeats-1; any mismatch SHALL set proto_err (sticky for the transaction).
REQ-021 After beat NumBeats-1 is accepted, RECV_CD SHALL go to SEND_RSP and set data_valid=1, regardless of last value.
REQ-022 SEND_RSP SHALL drive rsp_valid_o=1 with rsp_o stable until rsp_ready_i; then IDLE.
REQ-023 rsp_o.data SHALL be all-zero and data_valid=0 when dataTransfer was 0; crresp.error SHALL be passed through unchanged.
REQ-024 ac_valid, cr_ready, cd_ready, rsp_valid_o SHALL be 0 outside their owning state; cr_valid/cd_valid seen in other states SHALL be ignored.
REQ-025 Minimum latency accept-to-rsp_valid_o SHALL be 3 cycles without data, 3+NumBeats cycles with data, given ready partners.
REQ-026 Exactly one snoop SHALL be outstanding; no new command accepted before rsp handshake completes.

Reset
REQ-027 With rst_ni=0 at a clock edge, state SHALL become IDLE and all latched fields and the beat counter SHALL clear, including mid-transaction.
REQ-028 While rst_ni=0, req_ready_o, rsp_valid_o, ac_valid, cr_ready, cd_ready and busy_o SHALL be 0; rsp_o SHALL be all-zero after reset.

Structure
REQ-029 snoop_result_t SHALL be defined in snoop_pkg; acsnoop_t and crresp_t reused from snoop_pkg; FSM state enum local.
REQ-030 No sub-module; single FSM plus beat counter of width $clog2(NumBeats).

Verification
REQ-031 READ_SHARED to 0x8000_0040, ac_ready after 2 cycles, CR {dataTransfer=1,isShared=1}, beats 0x1111..., 0x2222... with last 0,1 -> rsp data=0x2222...1111..., data_valid=1, proto_err=0.
REQ-032 CLEAN_INVALID, CR dataTransfer=0 -> rsp after 3 cycles, data=0, data_valid=0, no cd_ready asserted.
REQ-033 READ_UNIQUE, CD beat0 last=1 -> proto_err=1, still two beats collected, FSM returns to IDLE.
REQ-034 rsp_ready_i held low 5 cycles, req_valid_i high -> rsp_o stable, req_ready_o=0 throughout; new command accepted cycle after rsp handshake.
REQ-035 rst_ni=0 during RECV_CD after beat 0 -> next cycle IDLE, outputs 0, following transaction returns correct data.
